// File: rtl/time_channel_selector.sv
// rtl/time_channel_selector.sv - N-channel time display selector with mode stepping, per-channel hold and mode LEDs
module time_channel_selector #(
    parameter int NUM_CH    = 4,
    parameter int MSEC_W    = 7,
    parameter int SEC_W     = 6,
    parameter int MIN_W     = 6,
    parameter int HOUR_W    = 5,
    parameter int BLINK_DIV = 50_000_000,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_mode,
    input  logic                     btn_hold,
    input  logic                     clr_hold,
    input  logic [NUM_CH*MSEC_W-1:0] ch_msec,
    input  logic [NUM_CH*SEC_W-1:0]  ch_sec,
    input  logic [NUM_CH*MIN_W-1:0]  ch_min,
    input  logic [NUM_CH*HOUR_W-1:0] ch_hour,
    output logic [CH_W-1:0]          sel,
    output logic [MSEC_W-1:0]        o_msec,
    output logic [SEC_W-1:0]         o_sec,
    output logic [MIN_W-1:0]         o_min,
    output logic [HOUR_W-1:0]        o_hour,
    output logic                     hold_active,
    output logic [NUM_CH-1:0]        led
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CH_W-1:0]    SEL_MAX   = CH_W'(NUM_CH - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    logic [MSEC_W-1:0] live_msec [NUM_CH];
    logic [SEC_W-1:0]  live_sec  [NUM_CH];
    logic [MIN_W-1:0]  live_min  [NUM_CH];
    logic [HOUR_W-1:0] live_hour [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign live_msec[k] = ch_msec[k*MSEC_W +: MSEC_W];
        assign live_sec[k]  = ch_sec[k*SEC_W +: SEC_W];
        assign live_min[k]  = ch_min[k*MIN_W +: MIN_W];
        assign live_hour[k] = ch_hour[k*HOUR_W +: HOUR_W];
    end

    logic [NUM_CH-1:0]  hold, hold_n;
    logic [MSEC_W-1:0]  snap_msec [NUM_CH];
    logic [SEC_W-1:0]   snap_sec  [NUM_CH];
    logic [MIN_W-1:0]   snap_min  [NUM_CH];
    logic [HOUR_W-1:0]  snap_hour [NUM_CH];
    logic [MSEC_W-1:0]  snap_msec_n [NUM_CH];
    logic [SEC_W-1:0]   snap_sec_n  [NUM_CH];
    logic [MIN_W-1:0]   snap_min_n  [NUM_CH];
    logic [HOUR_W-1:0]  snap_hour_n [NUM_CH];
    logic               prev_mode, prev_hold;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               blink_phase, blink_phase_n;
    logic [CH_W-1:0]    sel_n;
    logic               mode_edge, hold_edge;
    logic [MSEC_W-1:0]  o_msec_n;
    logic [SEC_W-1:0]   o_sec_n;
    logic [MIN_W-1:0]   o_min_n;
    logic [HOUR_W-1:0]  o_hour_n;
    logic [NUM_CH-1:0]  led_n;

    // Everything registered is computed from post-update state so the display
    // reflects a mode or hold change exactly one clock after the edge cycle.
    always_comb begin
        mode_edge     = btn_mode & ~prev_mode;
        hold_edge     = btn_hold & ~prev_hold;
        sel_n         = sel;
        hold_n        = hold;
        snap_msec_n   = snap_msec;
        snap_sec_n    = snap_sec;
        snap_min_n    = snap_min;
        snap_hour_n   = snap_hour;
        blink_cnt_n   = blink_cnt + 1'b1;
        blink_phase_n = blink_phase;

        if (clr_hold) begin
            hold_n = '0;
        end else if (hold_edge) begin
            hold_n[sel] = ~hold[sel];
            if (!hold[sel]) begin
                snap_msec_n[sel] = live_msec[sel];
                snap_sec_n[sel]  = live_sec[sel];
                snap_min_n[sel]  = live_min[sel];
                snap_hour_n[sel] = live_hour[sel];
            end
        end

        // Hold above uses the pre-increment channel; the step happens after.
        if (mode_edge) begin
            sel_n = (sel == SEL_MAX) ? '0 : sel + 1'b1;
        end

        if (blink_cnt == BLINK_MAX) begin
            blink_cnt_n   = '0;
            blink_phase_n = ~blink_phase;
        end

        if (hold_n[sel_n]) begin
            o_msec_n = snap_msec_n[sel_n];
            o_sec_n  = snap_sec_n[sel_n];
            o_min_n  = snap_min_n[sel_n];
            o_hour_n = snap_hour_n[sel_n];
        end else begin
            o_msec_n = live_msec[sel_n];
            o_sec_n  = live_sec[sel_n];
            o_min_n  = live_min[sel_n];
            o_hour_n = live_hour[sel_n];
        end

        led_n        = '0;
        led_n[sel_n] = hold_n[sel_n] ? blink_phase_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel         <= '0;
            hold        <= '0;
            prev_mode   <= 1'b0;
            prev_hold   <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            o_msec      <= '0;
            o_sec       <= '0;
            o_min       <= '0;
            o_hour      <= '0;
            hold_active <= 1'b0;
            led         <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_msec[k] <= '0;
                snap_sec[k]  <= '0;
                snap_min[k]  <= '0;
                snap_hour[k] <= '0;
            end
        end else begin
            sel         <= sel_n;
            hold        <= hold_n;
            prev_mode   <= btn_mode;
            prev_hold   <= btn_hold;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            o_msec      <= o_msec_n;
            o_sec       <= o_sec_n;
            o_min       <= o_min_n;
            o_hour      <= o_hour_n;
            hold_active <= hold_n[sel_n];
            led         <= led_n;
            snap_msec   <= snap_msec_n;
            snap_sec    <= snap_sec_n;
            snap_min    <= snap_min_n;
            snap_hour   <= snap_hour_n;
        end
    end

endmodule

// File: tb/tb_time_channel_selector.sv
// tb/tb_time_channel_selector.sv - self-checking bench for time_channel_selector
module tb_time_channel_selector;

    localparam int N  = 4;
    localparam int BD = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           btn_mode, btn_hold, clr_hold;
    logic [N*7-1:0] ch_msec;
    logic [N*6-1:0] ch_sec;
    logic [N*6-1:0] ch_min;
    logic [N*5-1:0] ch_hour;
    logic [1:0]     sel;
    logic [6:0]     o_msec;
    logic [5:0]     o_sec;
    logic [5:0]     o_min;
    logic [4:0]     o_hour;
    logic           hold_active;
    logic [N-1:0]   led;

    logic [6:0] lm [N];
    logic [5:0] ls [N];
    logic [5:0] ln [N];
    logic [4:0] lh [N];

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int m_sel;
    bit m_hold [N];
    int sm [N], ss [N], sn [N], sh [N];
    bit m_pm, m_ph, m_rst;
    int n_edges;

    time_channel_selector #(
        .NUM_CH(N), .MSEC_W(7), .SEC_W(6), .MIN_W(6), .HOUR_W(5), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_hold(btn_hold),
        .clr_hold(clr_hold), .ch_msec(ch_msec), .ch_sec(ch_sec), .ch_min(ch_min),
        .ch_hour(ch_hour), .sel(sel), .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min),
        .o_hour(o_hour), .hold_active(hold_active), .led(led)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_msec[k*7 +: 7] = lm[k];
            ch_sec[k*6 +: 6]  = ls[k];
            ch_min[k*6 +: 6]  = ln[k];
            ch_hour[k*5 +: 5] = lh[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_live();
        for (int k = 0; k < N; k++) begin
            lm[k] = 7'($urandom);
            ls[k] = 6'($urandom);
            ln[k] = 6'($urandom);
            lh[k] = 5'($urandom);
        end
    endtask

    task automatic tick();
        bit me, he, h, phase;
        @(posedge clk);
        if (!reset) begin
            m_sel = 0; m_pm = 0; m_ph = 0; n_edges = 0; m_rst = 1;
            for (int k = 0; k < N; k++) begin
                m_hold[k] = 0; sm[k] = 0; ss[k] = 0; sn[k] = 0; sh[k] = 0;
            end
        end else begin
            m_rst = 0;
            me = btn_mode && !m_pm;
            he = btn_hold && !m_ph;
            if (clr_hold) begin
                for (int k = 0; k < N; k++) m_hold[k] = 0;
            end else if (he) begin
                if (!m_hold[m_sel]) begin
                    sm[m_sel] = lm[m_sel]; ss[m_sel] = ls[m_sel];
                    sn[m_sel] = ln[m_sel]; sh[m_sel] = lh[m_sel];
                end
                m_hold[m_sel] = !m_hold[m_sel];
            end
            if (me) m_sel = (m_sel + 1) % N;
            m_pm = btn_mode;
            m_ph = btn_hold;
            n_edges++;
        end
        #1;
        if (m_rst) begin
            check("sel", sel, 0);
            check("o_msec", o_msec, 0);
            check("o_sec", o_sec, 0);
            check("o_min", o_min, 0);
            check("o_hour", o_hour, 0);
            check("hold_active", hold_active, 0);
            check("led", led, 0);
        end else begin
            h = m_hold[m_sel];
            phase = ((n_edges / BD) % 2) == 0;
            check("sel", sel, m_sel);
            check("o_msec", o_msec, h ? sm[m_sel] : lm[m_sel]);
            check("o_sec", o_sec, h ? ss[m_sel] : ls[m_sel]);
            check("o_min", o_min, h ? sn[m_sel] : ln[m_sel]);
            check("o_hour", o_hour, h ? sh[m_sel] : lh[m_sel]);
            check("hold_active", hold_active, h);
            check("led", led, (h ? phase : 1'b1) ? (1 << m_sel) : 0);
        end
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; tick();
    endtask

    task automatic pulse_hold();
        btn_hold = 1'b1; tick();
        btn_hold = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b0; btn_mode = 1'b0; btn_hold = 1'b0; clr_hold = 1'b0;
        rand_live();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("release_led", led, 4'b0001);

        // four 3-cycle mode pulses: one step each
        for (int p = 0; p < 4; p++) begin
            btn_mode = 1'b1;
            repeat (3) begin rand_live(); tick(); end
            btn_mode = 1'b0;
            repeat (2) tick();
            check("step_sel", sel, (p + 1) % N);
        end

        // freeze channel 1
        pulse_mode();
        ls[1] = 6'd12;
        btn_hold = 1'b1; tick();
        btn_hold = 1'b0;
        ls[1] = 6'd13; tick();
        ls[1] = 6'd14; tick();
        check("frozen_sec", o_sec, 12);
        check("frozen_active", hold_active, 1);
        repeat (10) begin rand_live(); tick(); end

        // visit channel 2 live and return to frozen channel 1
        ln[2] = 6'd5;
        pulse_mode();
        check("ch2_min", o_min, 5);
        check("ch2_active", hold_active, 0);
        repeat (3) pulse_mode();
        check("restored_sec", o_sec, 12);

        // simultaneous mode and hold edges at sel 2
        pulse_mode();
        btn_mode = 1'b1; btn_hold = 1'b1; tick();
        btn_mode = 1'b0; btn_hold = 1'b0; tick();
        check("simul_sel", sel, 3);
        check("simul_active", hold_active, 0);

        // hold channel 0, then clear all with a competing hold edge
        pulse_mode();
        pulse_hold();
        check("ch0_held", hold_active, 1);
        clr_hold = 1'b1; btn_hold = 1'b1; rand_live(); tick();
        clr_hold = 1'b0; btn_hold = 1'b0; rand_live(); tick();
        check("clr_active", hold_active, 0);
        repeat (2) begin pulse_mode(); rand_live(); end
        check("clr_ch2_active", hold_active, 0);

        // randomized operation
        repeat (300) begin
            btn_mode = ($urandom_range(0, 3) == 0);
            btn_hold = ($urandom_range(0, 3) == 0);
            clr_hold = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) rand_live();
            tick();
        end

        // mid-run reset
        btn_mode = 1'b0; btn_hold = 1'b0; clr_hold = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("post_reset_sel", sel, 0);
        check("post_reset_led", led, 4'b0001);
        repeat (20) begin
            btn_mode = ($urandom_range(0, 2) == 0);
            btn_hold = ($urandom_range(0, 2) == 0);
            rand_live();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/time_channel_selector.md
Name: time_channel_selector

Overview:
- Parametrised N-channel time-display selector with mode sequencing, per-channel display hold (freeze), and one-hot mode LEDs.
- Sits between the time sources (stopwatch, watch, future timer/alarm) and fnd_controller.
- Replaces the fixed 2:1 switch mux and static LED decode.
- Mode is stepped by button rising edges, not switch levels.

Parameters:
- NUM_CH, 4, number of time-source channels (1..16).
- MSEC_W, 7, msec field width.
- SEC_W, 6, sec field width.
- MIN_W, 6, min field width.
- HOUR_W, 5, hour field width.
- BLINK_DIV, 50_000_000, clk cycles per LED blink half-period (0.5 s at 100 MHz).
- Derived: CH_W = max(1, clog2(NUM_CH)); blink counter width = clog2(BLINK_DIV).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- btn_mode  in  1  debounced level; rising edge advances channel.
- btn_hold  in  1  debounced level; rising edge toggles hold on the current channel.
- clr_hold  in  1  level; while high, clears all holds.
- ch_msec  in  NUM_CH*MSEC_W  packed; channel k occupies bits [k*MSEC_W +: MSEC_W].
- ch_sec  in  NUM_CH*SEC_W  packed, same layout.
- ch_min  in  NUM_CH*MIN_W  packed, same layout.
- ch_hour  in  NUM_CH*HOUR_W  packed, same layout.
- sel  out  CH_W  current channel index.
- o_msec  out  MSEC_W  displayed msec.
- o_sec  out  SEC_W  displayed sec.
- o_min  out  MIN_W  displayed min.
- o_hour  out  HOUR_W  displayed hour.
- hold_active  out  1  hold flag of the current channel.
- led  out  NUM_CH  one-hot channel indicator.

Behaviour:
- Reset (reset==0 at a clk edge) clears:
  - sel, hold[], all snapshots, edge-detect registers, blink counter and blink phase.
  - o_* = 0, hold_active = 0.
  - led = 0 during reset; led = 1 (bit 0 set) on the first cycle after release.
- Edge detect: prev_mode and prev_hold are registered. An edge is btn & ~prev. A held button produces exactly one edge.
- Mode step: on a btn_mode edge, sel <= (sel==NUM_CH-1) ? 0 : sel+1. With NUM_CH==1, sel stays 0.
- Hold toggle: on a btn_hold edge, hold[sel] <= ~hold[sel].
  - On 0->1, snap[sel] <= the live ch_* fields of channel sel, sampled in the same cycle.
  - On 1->0, the snapshot is kept but no longer used.
- Simultaneous mode and hold edges in one cycle: the hold applies to the pre-increment sel, then sel advances.
- clr_hold high: all hold[] <= 0. It has priority over a same-cycle hold edge. sel is unaffected.
- Outputs are registered, one-cycle latency:
  - o_* <= hold[sel_next] ? snap[sel_next] : live ch[sel_next].
  - sel_next and hold_next are the post-update values.
  - Display therefore reflects a mode or hold change one clk after the edge cycle. A live channel tracks its input one cycle late.
- Hold state is per channel and persists across mode changes. Returning to a held channel shows its frozen snapshot.
- hold_active = hold[sel], registered with the outputs.
- LED:
  - When the current channel is not held, led = one-hot(sel), solid.
  - When it is held, bit sel blinks: the free-running blink counter wraps at BLINK_DIV-1 and toggles the phase. Phase 1 = on, and phase resets to 1.
  - All other led bits are 0.
- Out-of-range field values pass through unchanged; the block performs no BCD or range checking.

Test Plan:
- Reset, then release with NUM_CH=4 -> sel=0, led=4'b0001, o_*=0, hold_active=0.
- Four btn_mode pulses, each 3 cycles high -> sel steps 1,2,3,0 (one step per pulse); led 0010,0100,1000,0001.
- Channel 1 live sec=12; btn_hold edge; then input changes to 13, 14 -> o_sec stays 12; hold_active=1; led bit1 toggles every BLINK_DIV cycles (BLINK_DIV=4 in sim).
- Channel 1 held; mode to channel 2 (live min=5) and back to channel 1 -> o_min=5 on channel 2, then channel 1's snapshot is restored.
- btn_mode and btn_hold rise in the same cycle at sel=2 -> hold[2]=1, sel=3, hold_active=0.
- Holds set on channels 0 and 2; pulse clr_hold together with a btn_hold edge; then assert reset mid-run -> all holds cleared and outputs live after clr_hold; after reset, sel=0 and o_*=0.
